pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 80 ++++++++
 tb/tb_pc_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with redirect, stall hold and pending-redirect capture
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid,
    output logic              misalign_err
);
    typedef enum logic {RUN, PEND} state_t;

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] INCR     = ADDR_W'(STEP);

    state_t            state;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] aligned_target;
    logic              fetch_fire;

    assign aligned_target = redir_target & ~LOW_MASK;
    // rst gates the request so nothing is issued while the PC is being forced
    assign fetch_valid    = !rst && !stall && (state == RUN) && !redir_valid;
    assign fetch_fire     = fetch_valid && fetch_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            pend_target  <= '0;
            pc_out       <= RESET_VEC;
            id_pc        <= '0;
            id_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            // every redirect is captured either directly or into pend_target
            misalign_err <= redir_valid && |(redir_target & LOW_MASK);
            case (state)
                RUN: begin
                    if (redir_valid) begin
                        if (stall) begin
                            pend_target <= aligned_target;
                            state       <= PEND;
                        end else begin
                            pc_out   <= aligned_target;
                            id_valid <= 1'b0;
                        end
                    end else if (!stall) begin
                        if (fetch_fire) begin
                            pc_out   <= pc_out + INCR;
                            id_pc    <= pc_out;
                            id_valid <= 1'b1;
                        end else begin
                            id_valid <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (stall) begin
                        if (redir_valid) begin
                            pend_target <= aligned_target;
                        end
                    end else begin
                        pc_out   <= redir_valid ? aligned_target : pend_target;
                        id_valid <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit (32-bit and 8-bit instances)
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        fetch_ready;

    logic        fetch_valid, id_valid, misalign_err;
    logic [31:0] pc_out, id_pc;
    logic        fetch_valid8, id_valid8, misalign_err8;
    logic [7:0]  pc_out8, id_pc8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc_out(pc_out), .id_pc(id_pc),
        .id_valid(id_valid), .misalign_err(misalign_err)
    );

    pc_unit #(.ADDR_W(8), .RESET_VEC(8'h40), .STEP(4)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
        .redir_target(redir_target[7:0]), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid8), .pc_out(pc_out8), .id_pc(id_pc8),
        .id_valid(id_valid8), .misalign_err(misalign_err8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; fetch_ready = 1'b0;
        #2;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc8", {24'h0, pc_out8}, 32'h40);
        chk("rst_idv", {31'h0, id_valid}, 0);
        chk("rst_mis", {31'h0, misalign_err}, 0);
        chk("rst_fv", {31'h0, fetch_valid}, 0);

        @(negedge clk);
        rst = 1'b0; fetch_ready = 1'b1;
        #1;
        chk("rel_fv", {31'h0, fetch_valid}, 1);
        step();
        chk("seq1_pc", pc_out, 32'h4);
        chk("seq1_id", id_pc, 32'h0);
        chk("seq1_idv", {31'h0, id_valid}, 1);
        step();
        chk("seq2_pc", pc_out, 32'h8);
        chk("seq2_id", id_pc, 32'h4);
        step();
        chk("seq3_pc", pc_out, 32'hC);
        chk("seq3_id", id_pc, 32'h8);
        chk("seq3_pc8", {24'h0, pc_out8}, 32'h4C);
        step();
        chk("seq4_pc", pc_out, 32'h10);

        // unstalled aligned redirect wins over sequential fetch
        redir_valid = 1'b1; redir_target = 32'h100;
        #1;
        chk("redir_fv", {31'h0, fetch_valid}, 0);
        step();
        chk("redir_pc", pc_out, 32'h100);
        chk("redir_idv", {31'h0, id_valid}, 0);
        chk("redir_mis", {31'h0, misalign_err}, 0);
        redir_valid = 1'b0;
        step();
        chk("post_redir_id", id_pc, 32'h100);
        chk("post_redir_pc", pc_out, 32'h104);

        fetch_ready = 1'b0;
        step();
        chk("nordy_pc", pc_out, 32'h104);
        chk("nordy_idv", {31'h0, id_valid}, 0);
        fetch_ready = 1'b1;

        // stalled redirects: newest pending target wins
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h200;
        step();
        chk("pend_pc", pc_out, 32'h104);
        redir_valid = 1'b0;
        #1;
        chk("pend_fv", {31'h0, fetch_valid}, 0);
        step();
        redir_valid = 1'b1; redir_target = 32'h300;
        step();
        redir_valid = 1'b0;
        step();
        chk("pend2_pc", pc_out, 32'h104);
        stall = 1'b0;
        #1;
        chk("pend_unstall_fv", {31'h0, fetch_valid}, 0);
        step();
        chk("pend_out_pc", pc_out, 32'h300);
        chk("pend_out_idv", {31'h0, id_valid}, 0);
        step();
        chk("pend_next_pc", pc_out, 32'h304);
        chk("pend_next_id", id_pc, 32'h300);

        stall = 1'b1;
        step();
        chk("hold_pc", pc_out, 32'h304);
        chk("hold_id", id_pc, 32'h300);
        chk("hold_idv", {31'h0, id_valid}, 1);
        stall = 1'b0;

        // misaligned redirect
        redir_valid = 1'b1; redir_target = 32'h103;
        step();
        chk("mis_pc", pc_out, 32'h100);
        chk("mis_err", {31'h0, misalign_err}, 1);
        chk("mis_err8", {31'h0, misalign_err8}, 1);
        redir_valid = 1'b0;
        step();
        chk("mis_clear", {31'h0, misalign_err}, 0);
        chk("mis_next_pc", pc_out, 32'h104);

        // wrap-around on the 8-bit instance
        redir_valid = 1'b1; redir_target = 32'hFC;
        step();
        chk("wrap_pre_pc8", {24'h0, pc_out8}, 32'hFC);
        redir_valid = 1'b0;
        step();
        chk("wrap_pc8", {24'h0, pc_out8}, 32'h00);
        chk("wrap_id8", {24'h0, id_pc8}, 32'hFC);
        chk("wrap_mis8", {31'h0, misalign_err8}, 0);
        chk("wrap_pc32", pc_out, 32'h100);

        // reset while a redirect is pending
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h500;
        step();
        redir_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("prst_pc", pc_out, 32'h0);
        chk("prst_pc8", {24'h0, pc_out8}, 32'h40);
        chk("prst_idv", {31'h0, id_valid}, 0);
        chk("prst_fv", {31'h0, fetch_valid}, 0);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("prel_fv", {31'h0, fetch_valid}, 1);
        step();
        chk("prel_pc", pc_out, 32'h4);
        chk("prel_id", id_pc, 32'h0);
        chk("prel_idv", {31'h0, id_valid}, 1);
        chk("prel_pc8", {24'h0, pc_out8}, 32'h44);
        chk("prel_id8", {24'h0, id_pc8}, 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
